// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_OP,
    S_B1,
    S_B2,
    S_DONE
  } state_t;

  localparam logic [7:0] OP_NOP         = 8'h00;
  localparam logic [7:0] OP_AJMP        = 8'h01;
  localparam logic [7:0] OP_LJMP        = 8'h02;
  localparam logic [7:0] OP_INC_A       = 8'h04;
  localparam logic [7:0] OP_MOV_A_IMM   = 8'h74;
  localparam logic [7:0] OP_MOV_DIR_IMM = 8'h75;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: program ROM port, instruction handshake and jump redirect.
interface fetch_unit_if #(parameter int ADDR_W = 16);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rd_en;
  logic [7:0]        rom_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [7:0]        opcode;
  logic [7:0]        operand1;
  logic [7:0]        operand2;
  logic [1:0]        instr_len;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] next_pc;
  logic              jmp_load;
  logic [ADDR_W-1:0] jmp_addr;

  // Fetch unit side
  modport master (
    output rom_addr, rom_rd_en, instr_valid, opcode, operand1, operand2,
           instr_len, instr_pc, next_pc,
    input  rom_data, instr_ready, jmp_load, jmp_addr
  );

  // ROM / consumer / datapath side
  modport slave (
    input  rom_addr, rom_rd_en, instr_valid, opcode, operand1, operand2,
           instr_len, instr_pc, next_pc,
    output rom_data, instr_ready, jmp_load, jmp_addr
  );
endinterface

// File: rtl/fetch_unit_instr_len_decode.sv
// 8051 opcode -> instruction length (1..3 bytes), full 256-entry ISA map.
// Laid out by opcode column (low nibble) then row (high nibble).
module instr_len_decode
  import fetch_pkg::*;
(
  input  logic [7:0] i_opcode,
  output logic [1:0] o_len
);

  logic [3:0] w_hi;
  logic [3:0] w_lo;

  assign w_hi = i_opcode[7:4];
  assign w_lo = i_opcode[3:0];

  // Column-wise length lookup; anything not listed is a single byte
  always_comb begin
    o_len = LEN_1;
    case (w_lo)
      4'h0: begin
        case (w_hi)
          4'h1, 4'h2, 4'h3, 4'h9:                         o_len = LEN_3;
          4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hB,
          4'hC, 4'hD:                                     o_len = LEN_2;
          default:                                        o_len = LEN_1;
        endcase
      end
      // AJMP / ACALL in every row
      4'h1: o_len = LEN_2;
      4'h2: begin
        case (w_hi)
          4'h0, 4'h1:                                     o_len = LEN_3;
          4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA,
          4'hB, 4'hC, 4'hD:                               o_len = LEN_2;
          default:                                        o_len = LEN_1;
        endcase
      end
      4'h3: begin
        case (w_hi)
          4'h4, 4'h5, 4'h6:                               o_len = LEN_3;
          default:                                        o_len = LEN_1;
        endcase
      end
      4'h4: begin
        case (w_hi)
          4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9:       o_len = LEN_2;
          4'hB:                                           o_len = LEN_3;
          default:                                        o_len = LEN_1;
        endcase
      end
      4'h5: begin
        case (w_hi)
          4'h7, 4'h8, 4'hB, 4'hD:                         o_len = LEN_3;
          4'hA:                                           o_len = LEN_1;
          default:                                        o_len = LEN_2;
        endcase
      end
      4'h6, 4'h7: begin
        case (w_hi)
          4'h7, 4'h8, 4'hA:                               o_len = LEN_2;
          4'hB:                                           o_len = LEN_3;
          default:                                        o_len = LEN_1;
        endcase
      end
      default: begin
        case (w_hi)
          4'h7, 4'h8, 4'hA, 4'hD:                         o_len = LEN_2;
          4'hB:                                           o_len = LEN_3;
          default:                                        o_len = LEN_1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: reads 1-3 program bytes from a synchronous ROM,
// presents the assembled instruction on a valid/ready handshake and
// accepts jump redirects from the datapath.
//
// state   | meaning
// S_IDLE  | post-reset, nothing in flight
// S_ISSUE | read issued at pc (after reset or jump)
// S_OP    | opcode byte returning; decode length
// S_B1    | operand1 byte returning
// S_B2    | operand2 byte returning
// S_DONE  | instruction valid, waiting for ready
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic          clock,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_instr_pc;
  logic [ADDR_W-1:0] r_next_pc;
  logic              r_valid;
  logic [7:0]        r_opcode;
  logic [7:0]        r_op1;
  logic [7:0]        r_op2;
  logic [1:0]        r_len;

  logic [1:0]        w_len;
  logic              w_hs;
  logic              w_rd;
  logic [ADDR_W-1:0] w_addr;

  instr_len_decode u_len_decode (
    .i_opcode (bus.rom_data),
    .o_len    (w_len)
  );

  assign w_hs = r_valid && bus.instr_ready;

  // ROM request: the next byte is issued in the cycle the previous one returns.
  // A jump suppresses any read so only the redirect target is fetched.
  always_comb begin
    w_addr = r_pc;
    w_rd   = 1'b0;
    case (r_state)
      S_ISSUE: w_rd = 1'b1;
      S_OP: begin
        w_addr = r_pc + ADDR_W'(1);
        w_rd   = (w_len != LEN_1);
      end
      S_B1: begin
        w_addr = r_pc + ADDR_W'(2);
        w_rd   = (r_len == LEN_3);
      end
      S_DONE: begin
        w_addr = r_next_pc;
        w_rd   = w_hs;
      end
      default: ;
    endcase
    if (bus.jmp_load) w_rd = 1'b0;
  end

  // Fetch sequencer with registered instruction outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_VECTOR;
      r_valid    <= 1'b0;
      r_opcode   <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_len      <= LEN_1;
      r_instr_pc <= '0;
      r_next_pc  <= '0;
    end else if (bus.jmp_load) begin
      // Redirect wins over everything; a concurrent handshake still consumes.
      r_pc    <= bus.jmp_addr;
      r_state <= S_ISSUE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= S_ISSUE;
        S_ISSUE: r_state <= S_OP;
        S_OP: begin
          r_opcode   <= bus.rom_data;
          r_op1      <= '0;
          r_op2      <= '0;
          r_len      <= w_len;
          r_instr_pc <= r_pc;
          r_next_pc  <= r_pc + ADDR_W'(w_len);
          if (w_len != LEN_1) begin
            r_state <= S_B1;
          end else begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
          end
        end
        S_B1: begin
          r_op1 <= bus.rom_data;
          if (r_len == LEN_3) begin
            r_state <= S_B2;
          end else begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
          end
        end
        S_B2: begin
          r_op2   <= bus.rom_data;
          r_state <= S_DONE;
          r_valid <= 1'b1;
        end
        S_DONE: begin
          if (w_hs) begin
            r_pc    <= r_next_pc;
            r_valid <= 1'b0;
            r_state <= S_OP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_addr    = w_addr;
  assign bus.rom_rd_en   = w_rd;
  assign bus.instr_valid = r_valid;
  assign bus.opcode      = r_opcode;
  assign bus.operand1    = r_op1;
  assign bus.operand2    = r_op2;
  assign bus.instr_len   = r_len;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.next_pc     = r_next_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: opcode/length vector table plus
// hand-written sequences for handshake, jump, wrap and async reset.
module tb_fetch_unit;

  localparam int AW = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;

  fetch_unit_if #(.ADDR_W(AW)) bus ();

  fetch_unit #(.ADDR_W(AW), .RESET_VECTOR(16'h0000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Synchronous program ROM; unread cycles return a poison byte
  logic [7:0] rom [0:65535];
  always @(posedge clock) bus.rom_data <= bus.rom_rd_en ? rom[bus.rom_addr] : 8'hEE;

  // Handshake counter
  int hs_cnt = 0;
  always @(posedge clock) if (bus.instr_valid && bus.instr_ready) hs_cnt <= hs_cnt + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         len;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic chk_instr(input string tag, input logic [7:0] op, input logic [7:0] o1,
                           input logic [7:0] o2, input int len,
                           input logic [15:0] ipc, input logic [15:0] npc);
    chk({tag, "_valid"},  32'(bus.instr_valid), 1);
    chk({tag, "_opcode"}, 32'(bus.opcode),      32'(op));
    chk({tag, "_op1"},    32'(bus.operand1),    32'(o1));
    chk({tag, "_op2"},    32'(bus.operand2),    32'(o2));
    chk({tag, "_len"},    32'(bus.instr_len),   32'(len));
    chk({tag, "_ipc"},    32'(bus.instr_pc),    32'(ipc));
    chk({tag, "_npc"},    32'(bus.next_pc),     32'(npc));
  endtask

  task automatic chk_rd(input string tag, input logic en, input logic [15:0] addr);
    chk({tag, "_rd_en"}, 32'(bus.rom_rd_en), 32'(en));
    if (en) chk({tag, "_addr"}, 32'(bus.rom_addr), 32'(addr));
  endtask

  // Assert reset across a full cycle; returns at the negedge of release (cycle 0)
  task automatic do_reset();
    step();
    reset           = 1'b0;
    bus.jmp_load    = 1'b0;
    bus.instr_ready = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic wait_valid(input int max, output int cyc);
    cyc = 0;
    while (!bus.instr_valid && cyc < max) begin
      step();
      cyc++;
    end
    if (!bus.instr_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_valid: no instr_valid within %0d cycles", max);
    end
  endtask

  initial begin
    int h0;
    int cyc;
    logic [15:0] base;

    bus.instr_ready = 1'b0;
    bus.jmp_load    = 1'b0;
    bus.jmp_addr    = '0;
    for (int a = 0; a < 65536; a++) rom[a] = 8'h00;

    vecs[0]  = '{8'h00, 8'h5A, 8'h6B, 1, 8'h00, 8'h00};
    vecs[1]  = '{8'h02, 8'h12, 8'h34, 3, 8'h12, 8'h34};
    vecs[2]  = '{8'h74, 8'h5A, 8'h6B, 2, 8'h5A, 8'h00};
    vecs[3]  = '{8'h75, 8'hA0, 8'h55, 3, 8'hA0, 8'h55};
    vecs[4]  = '{8'h01, 8'h22, 8'h33, 2, 8'h22, 8'h00};
    vecs[5]  = '{8'h04, 8'h11, 8'h22, 1, 8'h00, 8'h00};
    vecs[6]  = '{8'hB4, 8'h10, 8'h20, 3, 8'h10, 8'h20};
    vecs[7]  = '{8'h80, 8'hFE, 8'h77, 2, 8'hFE, 8'h00};
    vecs[8]  = '{8'h85, 8'h11, 8'h22, 3, 8'h11, 8'h22};
    vecs[9]  = '{8'hD8, 8'hFE, 8'h44, 2, 8'hFE, 8'h00};
    vecs[10] = '{8'hA5, 8'h99, 8'h88, 1, 8'h00, 8'h00};
    vecs[11] = '{8'hE5, 8'h30, 8'h40, 2, 8'h30, 8'h00};
    vecs[12] = '{8'hB8, 8'h01, 8'h02, 3, 8'h01, 8'h02};
    vecs[13] = '{8'h43, 8'hF0, 8'h0F, 3, 8'hF0, 8'h0F};
    vecs[14] = '{8'h12, 8'h00, 8'h10, 3, 8'h00, 8'h10};
    vecs[15] = '{8'h22, 8'hAA, 8'hBB, 1, 8'h00, 8'h00};

    // Reset state
    reset = 1'b0;
    repeat (2) step();
    chk("rst_valid",  32'(bus.instr_valid), 0);
    chk("rst_rd_en",  32'(bus.rom_rd_en),   0);
    chk("rst_opcode", 32'(bus.opcode),      0);
    chk("rst_op1",    32'(bus.operand1),    0);
    chk("rst_op2",    32'(bus.operand2),    0);
    chk("rst_len",    32'(bus.instr_len),   1);
    chk("rst_ipc",    32'(bus.instr_pc),    0);
    chk("rst_npc",    32'(bus.next_pc),     0);

    // Seq1: 1-byte NOP after reset, valid in cycle 3
    rom[0] = 8'h00;
    reset  = 1'b1;
    #1 chk_rd("s1_c0", 1'b0, 16'h0000);
    step(); chk_rd("s1_c1", 1'b1, 16'h0000);
    chk("s1_c1_valid", 32'(bus.instr_valid), 0);
    step(); chk("s1_c2_valid", 32'(bus.instr_valid), 0);
    step(); chk_instr("s1_c3", 8'h00, 8'h00, 8'h00, 1, 16'h0000, 16'h0001);

    // Seq2: 3-byte LJMP back-to-back with ready held high
    rom[0] = 8'h02; rom[1] = 8'h12; rom[2] = 8'h34; rom[3] = 8'h00;
    do_reset();
    bus.instr_ready = 1'b1;
    step(); chk_rd("s2_c1", 1'b1, 16'h0000);
    step(); chk_rd("s2_c2", 1'b1, 16'h0001);
    step(); chk_rd("s2_c3", 1'b1, 16'h0002);
    step(); chk_rd("s2_c4", 1'b0, 16'h0000);
    chk("s2_c4_valid", 32'(bus.instr_valid), 0);
    step(); chk_instr("s2_c5", 8'h02, 8'h12, 8'h34, 3, 16'h0000, 16'h0003);
    chk_rd("s2_c5", 1'b1, 16'h0003);
    step(); chk("s2_c6_valid", 32'(bus.instr_valid), 0);
    step(); chk_instr("s2_c7", 8'h00, 8'h00, 8'h00, 1, 16'h0003, 16'h0004);

    // Seq3: backpressure holds outputs and suppresses reads
    rom[0] = 8'h74; rom[1] = 8'h5A; rom[2] = 8'h04;
    do_reset();
    repeat (4) step();
    chk_instr("s3_c4", 8'h74, 8'h5A, 8'h00, 2, 16'h0000, 16'h0002);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("s3_hold_valid", 32'(bus.instr_valid), 1);
      chk("s3_hold_opcode", 32'(bus.opcode), 32'h74);
      chk("s3_hold_op1", 32'(bus.operand1), 32'h5A);
      chk("s3_hold_rd_en", 32'(bus.rom_rd_en), 0);
    end
    h0 = hs_cnt;
    bus.instr_ready = 1'b1;
    #1 chk_rd("s3_accept", 1'b1, 16'h0002);
    step();
    bus.instr_ready = 1'b0;
    #1 chk("s3_after_valid", 32'(bus.instr_valid), 0);
    chk("s3_hs_count", 32'(hs_cnt - h0), 1);
    step(); chk_instr("s3_next", 8'h04, 8'h00, 8'h00, 1, 16'h0002, 16'h0003);

    // Seq4: jump while in S_B1 drops the partial instruction
    rom[0] = 8'h02; rom[1] = 8'h12; rom[2] = 8'h34;
    rom[16'h0100] = 8'h74; rom[16'h0101] = 8'h99;
    do_reset();
    repeat (3) step();
    bus.jmp_load = 1'b1;
    bus.jmp_addr = 16'h0100;
    #1 chk_rd("s4_jmp", 1'b0, 16'h0000);
    step();
    bus.jmp_load = 1'b0;
    #1 chk_rd("s4_issue", 1'b1, 16'h0100);
    chk("s4_issue_valid", 32'(bus.instr_valid), 0);
    step(); chk("s4_op_valid", 32'(bus.instr_valid), 0);
    step(); chk("s4_b1_valid", 32'(bus.instr_valid), 0);
    step(); chk_instr("s4_new", 8'h74, 8'h99, 8'h00, 2, 16'h0100, 16'h0102);

    // Seq5: jump coinciding with a handshake consumes exactly once
    rom[0] = 8'h04; rom[1] = 8'h00;
    rom[16'h0300] = 8'hE5; rom[16'h0301] = 8'h7C;
    do_reset();
    repeat (3) step();
    chk_instr("s5_first", 8'h04, 8'h00, 8'h00, 1, 16'h0000, 16'h0001);
    h0 = hs_cnt;
    bus.instr_ready = 1'b1;
    bus.jmp_load    = 1'b1;
    bus.jmp_addr    = 16'h0300;
    #1 chk_rd("s5_jmp", 1'b0, 16'h0000);
    step();
    bus.instr_ready = 1'b0;
    bus.jmp_load    = 1'b0;
    #1 chk("s5_hs_count", 32'(hs_cnt - h0), 1);
    chk("s5_issue_valid", 32'(bus.instr_valid), 0);
    chk_rd("s5_issue", 1'b1, 16'h0300);
    repeat (3) step();
    chk_instr("s5_target", 8'hE5, 8'h7C, 8'h00, 2, 16'h0300, 16'h0302);
    chk("s5_hs_final", 32'(hs_cnt - h0), 1);

    // Seq6: wrap at FFFF (jump from S_IDLE), then async reset mid S_B1
    rom[16'hFFFF] = 8'h02; rom[0] = 8'hAB; rom[1] = 8'hCD;
    rom[2] = 8'h02; rom[3] = 8'h11; rom[4] = 8'h22;
    do_reset();
    bus.jmp_load = 1'b1;
    bus.jmp_addr = 16'hFFFF;
    step();
    bus.jmp_load = 1'b0;
    #1 chk_rd("s6_c1", 1'b1, 16'hFFFF);
    step(); chk_rd("s6_c2", 1'b1, 16'h0000);
    step(); chk_rd("s6_c3", 1'b1, 16'h0001);
    step();
    step(); chk_instr("s6_wrap", 8'h02, 8'hAB, 8'hCD, 3, 16'hFFFF, 16'h0002);
    bus.instr_ready = 1'b1;
    #1 chk_rd("s6_accept", 1'b1, 16'h0002);
    step();
    bus.instr_ready = 1'b0;
    step();
    #2 reset = 1'b0;
    #1;
    chk("s6_arst_valid",  32'(bus.instr_valid), 0);
    chk("s6_arst_opcode", 32'(bus.opcode),      0);
    chk("s6_arst_len",    32'(bus.instr_len),   1);
    chk("s6_arst_ipc",    32'(bus.instr_pc),    0);
    chk("s6_arst_npc",    32'(bus.next_pc),     0);
    chk("s6_arst_rd_en",  32'(bus.rom_rd_en),   0);
    step();
    reset = 1'b1;
    step(); chk_rd("s6_restart", 1'b1, 16'h0000);
    repeat (3) step();
    chk_instr("s6_restart", 8'hAB, 8'hCD, 8'h00, 2, 16'h0000, 16'h0002);

    // Table: decode length, operand zeroing and fetch latency per opcode
    for (int i = 0; i < 16; i++) begin
      base = 16'h0200 + 16'(i * 16);
      rom[base]         = vecs[i].b0;
      rom[base + 16'd1] = vecs[i].b1;
      rom[base + 16'd2] = vecs[i].b2;
      bus.instr_ready = 1'b0;
      bus.jmp_load    = 1'b1;
      bus.jmp_addr    = base;
      step();
      bus.jmp_load = 1'b0;
      wait_valid(10, cyc);
      chk($sformatf("vec%0d_latency", i), 32'(cyc + 1), 32'(vecs[i].len + 2));
      chk_instr($sformatf("vec%0d", i), vecs[i].b0, vecs[i].e1, vecs[i].e2,
                vecs[i].len, base, base + 16'(vecs[i].len));
      bus.instr_ready = 1'b1;
      step();
      bus.instr_ready = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of control_unit/datapath. It reads program bytes from a synchronous program ROM and assembles each 8051 instruction (1–3 bytes: opcode plus up to 2 operands). It presents the instruction with a valid/ready handshake and takes jump redirects from the datapath.

Parameters:
ADDR_W, 16, program address width; PC wraps modulo 2^ADDR_W
RESET_VECTOR, 16'h0000, PC value after reset

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rom_addr  out  ADDR_W  program ROM byte address (combinational from state/PC)
rom_rd_en  out  1  ROM read strobe; data returns on rom_data exactly one cycle later
rom_data  in  8  ROM read data
instr_valid  out  1  assembled instruction available
instr_ready  in  1  consumer accepts instruction; handshake occurs on valid&&ready at rising edge
opcode  out  8  instruction opcode
operand1  out  8  second byte; 0 if length < 2
operand2  out  8  third byte; 0 if length < 3
instr_len  out  2  instruction length, 1..3
instr_pc  out  ADDR_W  address of the opcode byte
next_pc  out  ADDR_W  instr_pc+instr_len, modulo 2^ADDR_W
jmp_load  in  1  redirect request
jmp_addr  in  ADDR_W  redirect target

Behaviour:
- Reset (reset==0, async):
  - state=S_IDLE, pc=RESET_VECTOR, instr_valid=0, rom_rd_en=0.
  - opcode, operand1, operand2, instr_pc, next_pc = 0; instr_len=1.
- States and transitions:
  - S_IDLE: rd_en=0 → S_ISSUE.
  - S_ISSUE: rd_en=1, addr=pc → S_OP.
  - S_OP: capture opcode, len=instr_len_decode(rom_data). If len>1, issue pc+1 → S_B1; else → S_DONE.
  - S_B1: capture operand1. If len==3, issue pc+2 → S_B2; else → S_DONE.
  - S_B2: capture operand2 → S_DONE.
  - S_DONE: instr_valid=1. On ready: pc:=next_pc, issue rd at next_pc in the same cycle → S_OP (no bubble).
- Latency:
  - From S_IDLE, a 1-byte instruction is valid in cycle 3 (IDLE c0, ISSUE c1, OP c2, DONE c3).
  - Back-to-back throughput: 1-byte = 2 cycles/instr, 2-byte = 3, 3-byte = 4.
- Handshake:
  - While valid && !ready, all instruction outputs hold stable and no ROM read is issued.
  - instr_valid deasserts the cycle after acceptance unless the next instruction completes (it cannot; minimum is one S_OP cycle).
- Address arithmetic: pc+1, pc+2 and next_pc wrap modulo 2^ADDR_W (e.g. 3-byte instr at FFFF reads FFFF, 0000, 0001; next_pc=0002).
- jmp_load:
  - In any state (including S_IDLE): pc:=jmp_addr, state:=S_ISSUE, instr_valid:=0 next cycle.
  - Any ROM data returning in the following cycle is discarded.
- jmp_load together with valid&&ready: the handshake completes (instruction consumed once), and the jump wins over next_pc.
- jmp_load with instr_ready high but valid low: ready is ignored.
- Async reset mid-instruction: everything is cleared immediately and partial bytes are dropped; after release, fetch restarts at RESET_VECTOR via S_IDLE.

Decomposition:
- Package fetch_pkg:
  - state enum (S_IDLE, S_ISSUE, S_OP, S_B1, S_B2, S_DONE).
  - Opcode constants: OP_NOP=8'h00, OP_AJMP=8'h01, OP_LJMP=8'h02, OP_INC_A=8'h04, OP_MOV_A_IMM=8'h74, OP_MOV_DIR_IMM=8'h75.
  - LEN_1/2/3 constants.
- Sub-module instr_len_decode: a combinational 256-entry opcode→length table matching the full 8051 ISA, shared with control_unit.

Test Plan:
- Reset release, ROM[0]=00: rd at 0000 in cycle 1 → instr_valid cycle 3, opcode=00, len=1, instr_pc=0000, next_pc=0001, operands=0.
- ROM[0..2]=02 12 34, ready=1: reads 0000, 0001, 0002 on consecutive cycles → opcode=02, operand1=12, operand2=34, len=3, next_pc=0003; next rd at 0003 in the acceptance cycle.
- ROM[0..1]=74 5A, ready held 0 for 5 cycles: outputs stable and rom_rd_en=0 throughout; raise ready → one handshake, then fetch resumes at 0002.
- jmp_load=1 with jmp_addr=0100 while in S_B1: valid never asserts for the partial instruction; rd at 0100 next cycle, stale rom_data ignored, new instruction has instr_pc=0100.
- jmp_load with valid&&ready in the same cycle: exactly one instruction consumed, next fetch at jmp_addr rather than next_pc.
- PC=FFFF holding 3-byte 02 AB CD: reads FFFF, 0000, 0001 → next_pc=0002. Async reset asserted mid S_B1 → outputs zero immediately, fetch restarts at 0000.
